// File: rtl/patch_loader.sv
// Strip buffer feeding the patchifier: collects `size` raster rows of an RGB image,
// then presents each size x size patch of the strip, left to right, under valid/ready.
module patch_loader #(
  parameter int CHANNEL_SIZE  = 8,
  parameter int NUM_CHANNELS  = 3,
  parameter int PIXEL_WIDTH   = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int size          = 16,
  parameter int IMG_PATCHES_W = 4,
  parameter int IMG_PATCHES_H = 4,
  localparam int IMG_W   = size * IMG_PATCHES_W,
  localparam int NPATCH  = IMG_PATCHES_W * IMG_PATCHES_H,
  localparam int IDX_W   = (NPATCH > 1) ? $clog2(NPATCH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  input  logic                   pixel_sof,
  output logic                   pixel_ready,
  output logic [PIXEL_WIDTH-1:0] patch_cache [size][size],
  output logic                   patch_valid,
  input  logic                   patch_ready,
  output logic [IDX_W-1:0]       patch_index,
  output logic                   frame_done
);

  localparam int ROW_W = (size > 1)          ? $clog2(size)          : 1;
  localparam int COL_W = (IMG_W > 1)         ? $clog2(IMG_W)         : 1;
  localparam int PC_W  = (IMG_PATCHES_W > 1) ? $clog2(IMG_PATCHES_W) : 1;
  localparam int ST_W  = (IMG_PATCHES_H > 1) ? $clog2(IMG_PATCHES_H) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state;
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     col;
  logic [PC_W-1:0]      patch_col;
  logic [ST_W-1:0]      strip;
  logic [PIXEL_WIDTH-1:0] strip_buf [size][IMG_W];

  logic             accept;
  logic             xfer;
  logic             last_col;
  logic             last_row;
  logic             last_pc;
  logic             last_strip;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;

  // pixel_ready is only high in FILL, so it alone qualifies acceptance
  assign accept     = pixel_valid && pixel_ready;
  assign xfer       = patch_valid && patch_ready;
  assign last_col   = (col == COL_W'(IMG_W - 1));
  assign last_row   = (row == ROW_W'(size - 1));
  assign last_pc    = (patch_col == PC_W'(IMG_PATCHES_W - 1));
  assign last_strip = (strip == ST_W'(IMG_PATCHES_H - 1));
  assign wr_row     = pixel_sof ? '0 : row;
  assign wr_col     = pixel_sof ? '0 : col;
  assign frame_done = xfer && last_pc && last_strip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      row         <= '0;
      col         <= '0;
      patch_col   <= '0;
      strip       <= '0;
      patch_index <= '0;
      pixel_ready <= 1'b0;
      patch_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          pixel_ready <= 1'b1;
          if (accept) begin
            if (pixel_sof) begin
              // restart the frame: this pixel lands at (0,0), next one at (0,1)
              row         <= '0;
              col         <= COL_W'(1);
              strip       <= '0;
              patch_index <= '0;
            end else if (last_col) begin
              col <= '0;
              if (last_row) begin
                row         <= '0;
                patch_col   <= '0;
                state       <= DRAIN;
                pixel_ready <= 1'b0;
                patch_valid <= 1'b1;
              end else begin
                row <= row + ROW_W'(1);
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (last_pc) begin
              patch_col   <= '0;
              state       <= FILL;
              pixel_ready <= 1'b1;
              patch_valid <= 1'b0;
              if (last_strip) begin
                strip       <= '0;
                patch_index <= '0;
              end else begin
                strip       <= strip + ST_W'(1);
                patch_index <= patch_index + IDX_W'(1);
              end
            end else begin
              patch_col   <= patch_col + PC_W'(1);
              patch_index <= patch_index + IDX_W'(1);
            end
          end
        end
        default: begin
          state       <= FILL;
          pixel_ready <= 1'b0;
          patch_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < size; r++)
        for (int c = 0; c < IMG_W; c++)
          strip_buf[r][c] <= '0;
    end else if (accept) begin
      strip_buf[wr_row][wr_col] <= pixel_in;
    end
  end

  // Patch window: column slice of the strip selected by patch_col
  always_comb begin
    for (int r = 0; r < size; r++)
      for (int c = 0; c < size; c++)
        patch_cache[r][c] = strip_buf[r][COL_W'(int'(patch_col) * size + c)];
  end

endmodule

// File: tb/tb_patch_loader.sv
// Scoreboard bench for patch_loader on an 8x8 image with 4x4 patches; pixel value = y*8+x.
module tb_patch_loader;

  localparam int PW = 24;
  localparam int SZ = 4;
  localparam int CW = SZ * SZ * PW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_sof = 1'b0;
  logic          pixel_ready;
  logic [PW-1:0] patch_cache [SZ][SZ];
  logic          patch_valid;
  logic          patch_ready = 1'b1;
  logic [1:0]    patch_index;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    bit          fd;
    logic [CW-1:0] data;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;

  patch_loader #(
    .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .PIXEL_WIDTH(PW),
    .size(SZ), .IMG_PATCHES_W(2), .IMG_PATCHES_H(2)
  ) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_sof(pixel_sof), .pixel_ready(pixel_ready), .patch_cache(patch_cache),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_index(patch_index),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // patch p: strip p/2, patch column p%2; pixel (r,c) = (strip*4+r)*8 + pc*4 + c
  function automatic logic [CW-1:0] patch_data(int p);
    logic [CW-1:0] d;
    int s, pc;
    s = p / 2;
    pc = p % 2;
    d = '0;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        d[(r*SZ+c)*PW +: PW] = PW'((s*4 + r)*8 + pc*4 + c);
    return d;
  endfunction

  function automatic logic [CW-1:0] cur_cache();
    logic [CW-1:0] d;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        d[(r*SZ+c)*PW +: PW] = patch_cache[r][c];
    return d;
  endfunction

  task automatic push_patch(int p);
    exp_t e;
    e.idx = p;
    e.fd = (p == 3);
    e.data = patch_data(p);
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    for (int p = 0; p < 4; p++) push_patch(p);
  endtask

  task automatic send_range(int first, int last, bit sof0, bit bub);
    for (int v = first; v <= last; v++) begin
      int guard;
      if (bub)
        while ($urandom_range(1, 0) == 0) begin
          pixel_valid = 1'b0;
          @(posedge clk); #1;
        end
      pixel_in = PW'(v);
      pixel_sof = sof0 && (v == first);
      pixel_valid = 1'b1;
      guard = 0;
      while (!pixel_ready && guard < 1000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!pixel_ready) begin
        checks++;
        errors++;
        $display("FAIL pixel_ready_timeout: pixel %0d not accepted within 1000 cycles", v);
        pixel_valid = 1'b0;
        pixel_sof = 1'b0;
        return;
      end
      @(posedge clk); #1;
      chk("valid_after_pixel", CW'(patch_valid), CW'((v + 1) % 32 == 0));
    end
    pixel_valid = 1'b0;
    pixel_sof = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("scoreboard_empty", CW'(exp_q.size()), CW'(0));
  endtask

  // Monitor: pops one expected patch per observed transfer
  always @(negedge clk) begin
    if (reset && patch_valid && patch_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_patch: index %0d transferred, none expected", patch_index);
      end else begin
        mon_e = exp_q.pop_front();
        chk("patch_index", CW'(patch_index), CW'(mon_e.idx));
        chk("patch_cache", cur_cache(), mon_e.data);
        chk("frame_done", CW'(frame_done), CW'(mon_e.fd));
      end
    end else if (frame_done) begin
      chk("stray_frame_done", CW'(frame_done), CW'(0));
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_pixel_ready", CW'(pixel_ready), CW'(0));
    chk("rst_patch_valid", CW'(patch_valid), CW'(0));
    chk("rst_patch_index", CW'(patch_index), CW'(0));
    chk("rst_frame_done", CW'(frame_done), CW'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", CW'(pixel_ready), CW'(1));

    // single frame with latency probe after strip 0
    push_frame();
    send_range(0, 31, 1'b1, 1'b0);
    chk("lat_valid_t1", CW'(patch_valid), CW'(1));
    chk("lat_index_t1", CW'(patch_index), CW'(0));
    chk("lat_ready_t1", CW'(pixel_ready), CW'(0));
    @(posedge clk); #1;
    chk("lat_valid_t2", CW'(patch_valid), CW'(1));
    chk("lat_index_t2", CW'(patch_index), CW'(1));
    @(posedge clk); #1;
    chk("lat_valid_t3", CW'(patch_valid), CW'(0));
    chk("lat_ready_t3", CW'(pixel_ready), CW'(1));
    send_range(32, 63, 1'b0, 1'b0);
    wait_drain();

    // backpressure: patch held 5 cycles while a pixel is offered
    patch_ready = 1'b0;
    push_frame();
    send_range(0, 31, 1'b1, 1'b0);
    pixel_in = PW'(32);
    pixel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", CW'(patch_valid), CW'(1));
      chk("bp_index", CW'(patch_index), CW'(0));
      chk("bp_pixel_ready", CW'(pixel_ready), CW'(0));
      chk("bp_cache", cur_cache(), patch_data(0));
      @(posedge clk); #1;
    end
    patch_ready = 1'b1;
    send_range(32, 63, 1'b0, 1'b0);
    wait_drain();

    // input bubbles
    push_frame();
    send_range(0, 63, 1'b1, 1'b1);
    wait_drain();

    // mid-frame restart on the 11th pixel
    send_range(0, 9, 1'b0, 1'b0);
    push_frame();
    send_range(0, 63, 1'b1, 1'b0);
    wait_drain();

    // reset while patch 1 is presented
    patch_ready = 1'b0;
    push_patch(0);
    send_range(0, 31, 1'b1, 1'b0);
    patch_ready = 1'b1;
    @(posedge clk); #1;
    patch_ready = 1'b0;
    chk("pre_rst_index", CW'(patch_index), CW'(1));
    chk("pre_rst_valid", CW'(patch_valid), CW'(1));
    #2 reset = 1'b0;
    #1;
    chk("rst_drain_valid", CW'(patch_valid), CW'(0));
    chk("rst_drain_index", CW'(patch_index), CW'(0));
    chk("rst_drain_ready", CW'(pixel_ready), CW'(0));
    @(posedge clk); #1;
    chk("rst_hold_ready", CW'(pixel_ready), CW'(0));
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst_drain", CW'(pixel_ready), CW'(1));
    chk("cache_cleared", cur_cache(), CW'(0));
    patch_ready = 1'b1;
    push_frame();
    send_range(0, 63, 1'b1, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_loader.md
# patch_loader

Upstream feeder for the patchifier stage. Accepts an RGB image as a raster-order pixel stream, buffers one horizontal strip of `size` rows, then presents each `size`×`size` patch of that strip, left to right, as a 2-D `patch_cache` array under a valid/ready handshake. At the top level the patchifier's `en` is tied to `patch_valid & patch_ready`, and its input `patch_cache` is driven by this block's output.

## Interface
- `CHANNEL_SIZE`, 8, bits per colour channel
- `NUM_CHANNELS`, 3, channels per pixel (RGB)
- `PIXEL_WIDTH`, `CHANNEL_SIZE*NUM_CHANNELS`, pixel word width
- `size`, 16, patch edge in pixels
- `IMG_PATCHES_W`, 4, patches per image row; image width `IMG_W = size*IMG_PATCHES_W`
- `IMG_PATCHES_H`, 4, patches per image column; image height `size*IMG_PATCHES_H`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `pixel_in`  in  `PIXEL_WIDTH`  pixel, raster order
- `pixel_valid`  in  1  `pixel_in` valid
- `pixel_sof`  in  1  start of frame, qualified by `pixel_valid`
- `pixel_ready`  out  1  block can accept a pixel
- `patch_cache`  out  `PIXEL_WIDTH` × [`size`][`size`]  current patch, indexed [row][col]
- `patch_valid`  out  1  `patch_cache` holds a complete patch
- `patch_ready`  in  1  consumer accepts the patch
- `patch_index`  out  `$clog2(IMG_PATCHES_W*IMG_PATCHES_H)`  frame-relative index of the presented patch (raster order of patches)
- `frame_done`  out  1  one-cycle pulse on the transfer of the last patch of a frame

## Operation
- Storage: strip buffer `size` × `IMG_W` pixels. Counters: `row` (0..size-1), `col` (0..IMG_W-1), `patch_col` (0..IMG_PATCHES_W-1), `strip` (0..IMG_PATCHES_H-1).
- FSM states: FILL, DRAIN.
- FILL:
  - `pixel_ready`=1 and `patch_valid`=0.
  - A pixel is accepted when `pixel_valid & pixel_ready`. The accepted pixel is written to buf[row][col], then `col` increments. When `col` wraps from `IMG_W-1` to 0, `row` increments.
  - Acceptance at row=`size-1`, col=`IMG_W-1`: clear `row`, `col` and `patch_col`, then go to DRAIN.
- Start of frame:
  - An accepted pixel with `pixel_sof`=1 is written to buf[0][0].
  - `row`, `col` and `strip` are forced so that the next pixel goes to (0,1) and `strip`=0. This holds at any position, including mid-frame.
  - `pixel_sof` on the very first pixel after reset is legal and changes nothing.
- DRAIN:
  - `pixel_ready`=0 and `patch_valid`=1.
  - `patch_cache[r][c]` = buf[r][patch_col*size + c]. This is a combinational mux from registers and is stable while `patch_valid` is held.
  - `patch_index` = `strip*IMG_PATCHES_W + patch_col`.
  - On a transfer (`patch_valid & patch_ready`), `patch_col` increments.
  - Transfer at `patch_col`=`IMG_PATCHES_W-1`:
    - Go to FILL.
    - If `strip`=`IMG_PATCHES_H-1`: pulse `frame_done` in the transfer cycle and set `strip` to 0.
    - Otherwise: increment `strip`.
- Backpressure: while `patch_ready`=0, hold `patch_valid`, `patch_cache` and `patch_index` unchanged. No pixels are accepted in DRAIN, so the strip buffer is never overwritten before it is drained.
- Reset (asynchronous, on the falling edge of `reset`, also mid-operation):
  - State returns to FILL and all counters clear.
  - The strip buffer clears to 0.
  - `patch_valid`=0, `frame_done`=0, `patch_index`=0.
  - `pixel_ready` is gated to 0 while `reset`=0 and becomes 1 in the first cycle after release.

## Timing
- Last strip pixel accepted in cycle t: `patch_valid`=1 from cycle t+1.
- Back-to-back transfers are allowed, one patch per cycle while `patch_ready`=1. A strip drains in `IMG_PATCHES_W` cycles minimum.
- Last transfer of a strip in cycle u: `patch_valid`=0 and `pixel_ready`=1 in cycle u+1.
- Throughput: one pixel per cycle in FILL. Minimum cycles per strip = `size*IMG_W + IMG_PATCHES_W`.
- `frame_done` is high only in the cycle of the final transfer and is combinationally qualified by `patch_ready`.
- All outputs except `patch_cache` (a mux of registers) and `frame_done` are driven directly from registers or from the state.

## Test plan
Bench parameters: `size`=4, `IMG_PATCHES_W`=2, `IMG_PATCHES_H`=2 (8×8 image). Pixel value = y*8+x.

1. **Single frame.** Stream 64 pixels with `pixel_valid`=1 and `patch_ready`=1, `pixel_sof` on pixel 0.
   - Expect 4 patches with `patch_index` 0..3.
   - patch0[r][c]=r*8+c, patch1=r*8+c+4, patch2=(r+4)*8+c, patch3=(r+4)*8+c+4.
   - `frame_done` pulses exactly once, with patch 3.
2. **Latency.** Last pixel of strip 0 (value 31) accepted in cycle t.
   - Expect `patch_valid`=1 at t+1, transfers at t+1 and t+2, `pixel_ready`=1 at t+3.
3. **Backpressure.** Hold `patch_ready`=0 for 5 cycles after `patch_valid` rises.
   - `patch_valid` stays 1, `patch_index`=0, `patch_cache` is unchanged, `pixel_ready`=0.
   - Pixels driven during this window are not consumed.
4. **Input bubbles.** Toggle `pixel_valid` pseudo-randomly at 50%.
   - Expected patches are identical to scenario 1.
5. **Mid-frame restart.** Assert `pixel_sof` on the 11th pixel, then stream a full 64-pixel frame.
   - First `patch_valid` appears after 32 pixels counted from the sof pixel.
   - Patches match scenario 1 with `patch_index` 0..3.
6. **Reset in DRAIN.** Assert `reset`=0 while presenting patch 1, release, then stream a full frame.
   - `patch_valid`=0 immediately on assertion.
   - `pixel_ready`=1 in the cycle after release.
   - The next frame reproduces scenario 1 exactly.
